// File: rtl/ctrl_pipe_pkg.sv
// Shared definitions for the decode-side control pipeline: bundle layout,
// forwarding select encodings and the hard-wired zero register.
package ctrl_pipe_pkg;

    // Control bundle layout; regdst sits above aluop so it can be dropped
    // once the destination has been chosen at ID->EX capture.
    localparam int CTRL_WEN       = 0;
    localparam int CTRL_ALUSRC    = 1;
    localparam int CTRL_BRANCH    = 2;
    localparam int CTRL_MEMWRITE  = 3;
    localparam int CTRL_MEMREAD   = 4;
    localparam int CTRL_MEMTOREG  = 5;
    localparam int CTRL_ALUOP_LSB = 6;
    localparam int CTRL_ALUOP_W   = 3;
    localparam int CTRL_REGDST    = CTRL_ALUOP_LSB + CTRL_ALUOP_W;
    localparam int CTRL_W         = CTRL_REGDST + 1;

    localparam int REG_ZERO = 0;

    typedef enum logic [1:0] {
        FWD_RF  = 2'b00,
        FWD_WB  = 2'b01,
        FWD_MEM = 2'b10
    } fwd_sel_e;

endpackage

// File: rtl/ctrl_pipe_hazard.sv
// Combinational hazard unit: load-use stall, branch flush and EX-stage
// operand forwarding selects.
module ctrl_hazard
    import ctrl_pipe_pkg::*;
#(
    parameter int REG_AW = 5
) (
    input  logic              id_valid,
    input  logic              id_alusrc,
    input  logic              id_memwrite,
    input  logic [REG_AW-1:0] id_rs,
    input  logic [REG_AW-1:0] id_rt,
    input  logic              ex_valid,
    input  logic              ex_memread,
    input  logic              ex_branch,
    input  logic              ex_zero,
    input  logic [REG_AW-1:0] ex_dest,
    input  logic [REG_AW-1:0] ex_rs,
    input  logic [REG_AW-1:0] ex_rt,
    input  logic              mem_valid,
    input  logic              mem_wen,
    input  logic [REG_AW-1:0] mem_dest,
    input  logic              wb_valid,
    input  logic              wb_wen,
    input  logic [REG_AW-1:0] wb_dest,
    output logic              stall,
    output logic              flush,
    output logic [1:0]        fwd_a,
    output logic [1:0]        fwd_b
);

    localparam logic [REG_AW-1:0] ZERO_REG = REG_AW'(REG_ZERO);

    logic uses_rt;
    logic load_match;
    logic mem_fwd_ok;
    logic wb_fwd_ok;

    always_comb begin
        flush      = ex_valid & ex_branch & ex_zero;
        uses_rt    = ~id_alusrc | id_memwrite;
        load_match = (ex_dest == id_rs) | (uses_rt & (ex_dest == id_rt));
        // A taken branch squashes the dependent instruction anyway, so it wins.
        stall      = id_valid & ex_valid & ex_memread & (ex_dest != ZERO_REG)
                     & load_match & ~flush;
    end

    always_comb begin
        mem_fwd_ok = mem_valid & mem_wen & (mem_dest != ZERO_REG);
        wb_fwd_ok  = wb_valid & wb_wen & (wb_dest != ZERO_REG);

        fwd_a = FWD_RF;
        if (mem_fwd_ok && (mem_dest == ex_rs)) begin
            fwd_a = FWD_MEM;
        end else if (wb_fwd_ok && (wb_dest == ex_rs)) begin
            fwd_a = FWD_WB;
        end

        fwd_b = FWD_RF;
        if (mem_fwd_ok && (mem_dest == ex_rt)) begin
            fwd_b = FWD_MEM;
        end else if (wb_fwd_ok && (wb_dest == ex_rt)) begin
            fwd_b = FWD_WB;
        end
    end

endmodule

// File: rtl/ctrl_pipe.sv
// Control pipeline: carries the decoded control word through ID/EX, EX/MEM
// and MEM/WB, choosing the destination register on entry to EX.
module ctrl_pipe
    import ctrl_pipe_pkg::*;
#(
    parameter int REG_AW  = 5,
    parameter int ALUOP_W = 3
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               id_valid,
    input  logic               id_wen,
    input  logic               id_alusrc,
    input  logic [ALUOP_W-1:0] id_aluop,
    input  logic               id_regdst,
    input  logic               id_branch,
    input  logic               id_memwrite,
    input  logic               id_memread,
    input  logic               id_memtoreg,
    input  logic [REG_AW-1:0]  id_rs,
    input  logic [REG_AW-1:0]  id_rt,
    input  logic [REG_AW-1:0]  id_rd,
    input  logic               ex_zero,
    output logic               ex_valid,
    output logic               ex_wen,
    output logic               ex_alusrc,
    output logic               ex_memwrite,
    output logic               ex_memread,
    output logic               ex_memtoreg,
    output logic               ex_branch,
    output logic [ALUOP_W-1:0] ex_aluop,
    output logic [REG_AW-1:0]  ex_dest,
    output logic               mem_valid,
    output logic               mem_wen,
    output logic               mem_memwrite,
    output logic               mem_memread,
    output logic               mem_memtoreg,
    output logic [REG_AW-1:0]  mem_dest,
    output logic               wb_valid,
    output logic               wb_wen,
    output logic               wb_memtoreg,
    output logic [REG_AW-1:0]  wb_dest,
    output logic               stall,
    output logic               flush,
    output logic [1:0]         fwd_a,
    output logic [1:0]         fwd_b
);

    localparam int REGDST_BIT = CTRL_ALUOP_LSB + ALUOP_W;
    localparam int BUNDLE_W   = REGDST_BIT + 1;
    localparam int EX_CTRL_W  = REGDST_BIT;

    logic [BUNDLE_W-1:0]  id_bundle;
    logic                 capture;

    logic                 ex_valid_d, ex_valid_q;
    logic [EX_CTRL_W-1:0] ex_ctrl_d, ex_ctrl_q;
    logic [REG_AW-1:0]    ex_dest_d, ex_dest_q;
    logic [REG_AW-1:0]    ex_rs_d, ex_rs_q;
    logic [REG_AW-1:0]    ex_rt_d, ex_rt_q;

    logic                 mem_valid_d, mem_valid_q;
    logic                 mem_wen_d, mem_wen_q;
    logic                 mem_memwrite_d, mem_memwrite_q;
    logic                 mem_memread_d, mem_memread_q;
    logic                 mem_memtoreg_d, mem_memtoreg_q;
    logic [REG_AW-1:0]    mem_dest_d, mem_dest_q;

    logic                 wb_valid_d, wb_valid_q;
    logic                 wb_wen_d, wb_wen_q;
    logic                 wb_memtoreg_d, wb_memtoreg_q;
    logic [REG_AW-1:0]    wb_dest_d, wb_dest_q;

    always_comb begin
        id_bundle                               = '0;
        id_bundle[CTRL_WEN]                     = id_wen;
        id_bundle[CTRL_ALUSRC]                  = id_alusrc;
        id_bundle[CTRL_BRANCH]                  = id_branch;
        id_bundle[CTRL_MEMWRITE]                = id_memwrite;
        id_bundle[CTRL_MEMREAD]                 = id_memread;
        id_bundle[CTRL_MEMTOREG]                = id_memtoreg;
        id_bundle[CTRL_ALUOP_LSB +: ALUOP_W]    = id_aluop;
        id_bundle[REGDST_BIT]                   = id_regdst;
    end

    ctrl_hazard #(.REG_AW(REG_AW)) u_hazard (
        .id_valid    (id_valid),
        .id_alusrc   (id_alusrc),
        .id_memwrite (id_memwrite),
        .id_rs       (id_rs),
        .id_rt       (id_rt),
        .ex_valid    (ex_valid_q),
        .ex_memread  (ex_ctrl_q[CTRL_MEMREAD]),
        .ex_branch   (ex_ctrl_q[CTRL_BRANCH]),
        .ex_zero     (ex_zero),
        .ex_dest     (ex_dest_q),
        .ex_rs       (ex_rs_q),
        .ex_rt       (ex_rt_q),
        .mem_valid   (mem_valid_q),
        .mem_wen     (mem_wen_q),
        .mem_dest    (mem_dest_q),
        .wb_valid    (wb_valid_q),
        .wb_wen      (wb_wen_q),
        .wb_dest     (wb_dest_q),
        .stall       (stall),
        .flush       (flush),
        .fwd_a       (fwd_a),
        .fwd_b       (fwd_b)
    );

    // Anything other than a clean, unblocked ID instruction enters EX as an all-zero bubble.
    always_comb begin
        capture    = id_valid & ~stall & ~flush;
        ex_valid_d = capture;
        ex_ctrl_d  = '0;
        ex_dest_d  = '0;
        ex_rs_d    = '0;
        ex_rt_d    = '0;
        if (capture) begin
            ex_ctrl_d = id_bundle[EX_CTRL_W-1:0];
            ex_dest_d = id_bundle[REGDST_BIT] ? id_rd : id_rt;
            ex_rs_d   = id_rs;
            ex_rt_d   = id_rt;
        end
    end

    always_comb begin
        mem_valid_d    = ex_valid_q;
        mem_wen_d      = ex_valid_q & ex_ctrl_q[CTRL_WEN];
        mem_memwrite_d = ex_valid_q & ex_ctrl_q[CTRL_MEMWRITE];
        mem_memread_d  = ex_valid_q & ex_ctrl_q[CTRL_MEMREAD];
        mem_memtoreg_d = ex_valid_q & ex_ctrl_q[CTRL_MEMTOREG];
        mem_dest_d     = ex_dest_q;

        wb_valid_d     = mem_valid_q;
        wb_wen_d       = mem_valid_q & mem_wen_q;
        wb_memtoreg_d  = mem_valid_q & mem_memtoreg_q;
        wb_dest_d      = mem_dest_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ex_valid_q     <= 1'b0;
            ex_ctrl_q      <= '0;
            ex_dest_q      <= '0;
            ex_rs_q        <= '0;
            ex_rt_q        <= '0;
            mem_valid_q    <= 1'b0;
            mem_wen_q      <= 1'b0;
            mem_memwrite_q <= 1'b0;
            mem_memread_q  <= 1'b0;
            mem_memtoreg_q <= 1'b0;
            mem_dest_q     <= '0;
            wb_valid_q     <= 1'b0;
            wb_wen_q       <= 1'b0;
            wb_memtoreg_q  <= 1'b0;
            wb_dest_q      <= '0;
        end else begin
            ex_valid_q     <= ex_valid_d;
            ex_ctrl_q      <= ex_ctrl_d;
            ex_dest_q      <= ex_dest_d;
            ex_rs_q        <= ex_rs_d;
            ex_rt_q        <= ex_rt_d;
            mem_valid_q    <= mem_valid_d;
            mem_wen_q      <= mem_wen_d;
            mem_memwrite_q <= mem_memwrite_d;
            mem_memread_q  <= mem_memread_d;
            mem_memtoreg_q <= mem_memtoreg_d;
            mem_dest_q     <= mem_dest_d;
            wb_valid_q     <= wb_valid_d;
            wb_wen_q       <= wb_wen_d;
            wb_memtoreg_q  <= wb_memtoreg_d;
            wb_dest_q      <= wb_dest_d;
        end
    end

    assign ex_valid     = ex_valid_q;
    assign ex_wen       = ex_ctrl_q[CTRL_WEN];
    assign ex_alusrc    = ex_ctrl_q[CTRL_ALUSRC];
    assign ex_memwrite  = ex_ctrl_q[CTRL_MEMWRITE];
    assign ex_memread   = ex_ctrl_q[CTRL_MEMREAD];
    assign ex_memtoreg  = ex_ctrl_q[CTRL_MEMTOREG];
    assign ex_branch    = ex_ctrl_q[CTRL_BRANCH];
    assign ex_aluop     = ex_ctrl_q[CTRL_ALUOP_LSB +: ALUOP_W];
    assign ex_dest      = ex_dest_q;

    assign mem_valid    = mem_valid_q;
    assign mem_wen      = mem_wen_q;
    assign mem_memwrite = mem_memwrite_q;
    assign mem_memread  = mem_memread_q;
    assign mem_memtoreg = mem_memtoreg_q;
    assign mem_dest     = mem_dest_q;

    assign wb_valid     = wb_valid_q;
    assign wb_wen       = wb_wen_q;
    assign wb_memtoreg  = wb_memtoreg_q;
    assign wb_dest      = wb_dest_q;

endmodule

// File: tb/tb_ctrl_pipe.sv
// Directed bench for ctrl_pipe: an instruction-level pipeline model checked
// every cycle, plus hand-computed literal checks along the directed program.
module tb_ctrl_pipe;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       id_valid, id_wen, id_alusrc, id_regdst, id_branch;
    logic       id_memwrite, id_memread, id_memtoreg, ex_zero;
    logic [2:0] id_aluop;
    logic [4:0] id_rs, id_rt, id_rd;

    logic       ex_valid, ex_wen, ex_alusrc, ex_memwrite, ex_memread, ex_memtoreg, ex_branch;
    logic [2:0] ex_aluop;
    logic [4:0] ex_dest, mem_dest, wb_dest;
    logic       mem_valid, mem_wen, mem_memwrite, mem_memread, mem_memtoreg;
    logic       wb_valid, wb_wen, wb_memtoreg;
    logic       stall, flush;
    logic [1:0] fwd_a, fwd_b;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    ctrl_pipe dut (
        .clk(clk), .rst_n(rst_n),
        .id_valid(id_valid), .id_wen(id_wen), .id_alusrc(id_alusrc), .id_aluop(id_aluop),
        .id_regdst(id_regdst), .id_branch(id_branch), .id_memwrite(id_memwrite),
        .id_memread(id_memread), .id_memtoreg(id_memtoreg),
        .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd), .ex_zero(ex_zero),
        .ex_valid(ex_valid), .ex_wen(ex_wen), .ex_alusrc(ex_alusrc), .ex_memwrite(ex_memwrite),
        .ex_memread(ex_memread), .ex_memtoreg(ex_memtoreg), .ex_branch(ex_branch),
        .ex_aluop(ex_aluop), .ex_dest(ex_dest),
        .mem_valid(mem_valid), .mem_wen(mem_wen), .mem_memwrite(mem_memwrite),
        .mem_memread(mem_memread), .mem_memtoreg(mem_memtoreg), .mem_dest(mem_dest),
        .wb_valid(wb_valid), .wb_wen(wb_wen), .wb_memtoreg(wb_memtoreg), .wb_dest(wb_dest),
        .stall(stall), .flush(flush), .fwd_a(fwd_a), .fwd_b(fwd_b)
    );

    // ---------------- instruction-level model ----------------
    typedef struct packed {
        bit       v;
        bit       wen, alusrc, mw, mr, mtr, br;
        bit [2:0] aluop;
        bit [4:0] dest, rs, rt;
    } instr_t;

    instr_t m_ex, m_mem, m_wb;

    function automatic bit m_flush();
        return m_ex.v && m_ex.br && ex_zero;
    endfunction

    function automatic bit m_stall();
        bit uses_rt;
        bit hit;
        uses_rt = !id_alusrc || id_memwrite;
        hit = (m_ex.dest == id_rs) || (uses_rt && m_ex.dest == id_rt);
        return id_valid && m_ex.v && m_ex.mr && m_ex.dest != 0 && hit && !m_flush();
    endfunction

    function automatic bit [1:0] m_fwd(input bit [4:0] src);
        if (m_mem.v && m_mem.wen && m_mem.dest != 0 && m_mem.dest == src) return 2'b10;
        if (m_wb.v && m_wb.wen && m_wb.dest != 0 && m_wb.dest == src) return 2'b01;
        return 2'b00;
    endfunction

    function automatic instr_t id_instr();
        instr_t r;
        r = '0;
        r.v = 1'b1;
        r.wen = id_wen; r.alusrc = id_alusrc; r.mw = id_memwrite; r.mr = id_memread;
        r.mtr = id_memtoreg; r.br = id_branch; r.aluop = id_aluop;
        r.dest = id_regdst ? id_rd : id_rt;
        r.rs = id_rs; r.rt = id_rt;
        return r;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_ex = '0; m_mem = '0; m_wb = '0;
        end else begin
            instr_t nxt;
            nxt = (id_valid && !m_stall() && !m_flush()) ? id_instr() : '0;
            m_wb  = m_mem;
            m_mem = m_ex;
            m_ex  = nxt;
        end
    end

    // ---------------- checking ----------------
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    always @(negedge clk) begin
        chk("ex_stage", {17'd0, ex_valid, ex_wen, ex_alusrc, ex_memwrite, ex_memread,
                         ex_memtoreg, ex_branch, ex_aluop, ex_dest},
            {17'd0, m_ex.v, m_ex.wen, m_ex.alusrc, m_ex.mw, m_ex.mr,
             m_ex.mtr, m_ex.br, m_ex.aluop, m_ex.dest});
        chk("mem_stage", {22'd0, mem_valid, mem_wen, mem_memwrite, mem_memread, mem_memtoreg, mem_dest},
            {22'd0, m_mem.v, m_mem.v & m_mem.wen, m_mem.v & m_mem.mw, m_mem.v & m_mem.mr,
             m_mem.v & m_mem.mtr, m_mem.dest});
        chk("wb_stage", {24'd0, wb_valid, wb_wen, wb_memtoreg, wb_dest},
            {24'd0, m_wb.v, m_wb.v & m_wb.wen, m_wb.v & m_wb.mtr, m_wb.dest});
        chk("hazard", {26'd0, stall, flush, fwd_a, fwd_b},
            {26'd0, m_stall(), m_flush(), m_fwd(m_ex.rs), m_fwd(m_ex.rt)});
    end

    // ---------------- drivers ----------------
    task automatic set_id(input bit v, input bit wen, input bit alusrc, input bit [2:0] aluop,
                          input bit regdst, input bit br, input bit mw, input bit mr,
                          input bit mtr, input bit [4:0] rs, input bit [4:0] rt, input bit [4:0] rd);
        id_valid = v; id_wen = wen; id_alusrc = alusrc; id_aluop = aluop; id_regdst = regdst;
        id_branch = br; id_memwrite = mw; id_memread = mr; id_memtoreg = mtr;
        id_rs = rs; id_rt = rt; id_rd = rd;
    endtask

    task automatic op_nop();                                set_id(0,0,0,3'd0,0,0,0,0,0,0,0,0); endtask
    task automatic op_add(input bit [4:0] rd, rs, rt);      set_id(1,1,0,3'd2,1,0,0,0,1,rs,rt,rd); endtask
    task automatic op_addi(input bit [4:0] rt, rs, rd);     set_id(1,1,1,3'd2,0,0,0,0,1,rs,rt,rd); endtask
    task automatic op_lw(input bit [4:0] rt, rs);           set_id(1,1,1,3'd2,0,0,0,1,0,rs,rt,0); endtask
    task automatic op_sw(input bit [4:0] rt, rs);           set_id(1,0,1,3'd2,0,0,1,0,0,rs,rt,0); endtask
    task automatic op_beq(input bit [4:0] rs, rt);          set_id(1,0,0,3'd6,0,1,0,0,0,rs,rt,0); endtask

    task automatic tick(input int n = 1);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #2;
        end
    endtask

    initial begin
        ex_zero = 1'b0;
        // Reset held with a live ADD on the inputs.
        op_add(5'd3, 5'd1, 5'd2);
        tick(2);
        chk("rst_ex_valid", ex_valid, 0);
        chk("rst_mem_valid", mem_valid, 0);
        chk("rst_wb_wen", wb_wen, 0);
        chk("rst_stall_fwd", {stall, flush, fwd_a, fwd_b}, 0);
        rst_n = 1'b1;
        tick();
        op_nop();
        tick(2);
        chk("first_wb_wen", wb_wen, 1);
        chk("first_wb_dest", wb_dest, 3);

        // Destination selection.
        op_addi(5'd4, 5'd1, 5'd9);
        tick();
        chk("regdst_rt", ex_dest, 4);
        op_add(5'd9, 5'd1, 5'd4);
        tick();
        chk("regdst_rd", ex_dest, 9);

        // Load-use on rs.
        op_lw(5'd5, 5'd1);
        tick();
        op_add(5'd8, 5'd5, 5'd2);
        #1 chk("lu_stall", stall, 1);
        tick();
        chk("lu_bubble", ex_valid, 0);
        chk("lu_stall_clear", stall, 0);
        tick();
        chk("lu_add_in_ex", {ex_valid, ex_dest}, {1'b1, 5'd8});
        chk("lu_fwd_a_wb", fwd_a, 2'b01);
        op_nop();
        tick(3);

        // Store uses rt; ADDI does not.
        op_lw(5'd6, 5'd1);
        tick();
        op_sw(5'd6, 5'd1);
        #1 chk("sw_rt_stall", stall, 1);
        op_addi(5'd6, 5'd2, 5'd0);
        #1 chk("addi_rt_nostall", stall, 0);
        op_nop();
        tick(3);

        // Branch taken, not taken, and flush beating a load-use match.
        op_beq(5'd1, 5'd2);
        tick();
        op_add(5'd10, 5'd1, 5'd2);
        ex_zero = 1'b1;
        #1 chk("beq_flush", flush, 1);
        tick();
        chk("beq_squash", ex_valid, 0);
        chk("beq_in_mem", {mem_valid, mem_wen, mem_memwrite}, 3'b100);
        ex_zero = 1'b0;
        op_beq(5'd1, 5'd2);
        tick();
        op_add(5'd10, 5'd1, 5'd2);
        #1 chk("beq_not_taken", flush, 0);
        tick();
        chk("beq_nt_ex", {ex_valid, ex_dest}, {1'b1, 5'd10});
        set_id(1,1,1,3'd2,0,1,0,1,0,5'd1,5'd5,5'd0);
        tick();
        op_add(5'd11, 5'd5, 5'd0);
        ex_zero = 1'b1;
        #1 chk("flush_over_stall", {stall, flush}, 2'b01);
        tick();
        chk("flush_over_stall_ex", ex_valid, 0);
        ex_zero = 1'b0;
        op_nop();
        tick(3);

        // Forwarding priority and register zero.
        op_add(5'd7, 5'd1, 5'd2);
        tick();
        op_add(5'd7, 5'd3, 5'd4);
        tick();
        op_add(5'd12, 5'd7, 5'd0);
        tick();
        chk("fwd_mem_prio", {fwd_a, fwd_b}, 4'b1000);
        op_add(5'd7, 5'd1, 5'd2);
        tick();
        op_nop();
        tick();
        op_add(5'd12, 5'd7, 5'd7);
        tick();
        chk("fwd_wb", {fwd_a, fwd_b}, 4'b0101);
        op_add(5'd0, 5'd1, 5'd2);
        tick();
        op_add(5'd12, 5'd0, 5'd0);
        tick();
        chk("fwd_r0", {fwd_a, fwd_b}, 4'b0000);
        op_nop();
        tick(3);

        // Reset mid-stream clears everything, then the pipe restarts empty.
        op_add(5'd13, 5'd1, 5'd2);
        tick(2);
        rst_n = 1'b0;
        #1 chk("midrst_clear", {ex_valid, mem_valid, mem_wen, ex_dest}, 0);
        tick();
        rst_n = 1'b1;
        op_add(5'd14, 5'd1, 5'd2);
        tick();
        chk("midrst_restart", {ex_valid, ex_dest, mem_valid}, {1'b1, 5'd14, 1'b0});
        op_nop();
        tick(3);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
